// File: rtl/g10_link_ctrl.sv
// g10_link_ctrl: bring-up and recovery sequencer for one 10GBASE-R PCS/PMA wrapper instance.
// Optional feature: define G10_LINK_DEBOUNCE_EN to require DEBOUNCE consecutive loss cycles before ST_UP drops.
module g10_link_ctrl #(
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned TX_TIMEOUT   = 65536,
  parameter int unsigned LOCK_TIMEOUT = 262144,
  parameter int unsigned HOLDOFF      = 1024,
  parameter int unsigned DEBOUNCE     = 64,
  parameter int unsigned RETRY_W      = 8
) (
  input  logic               clk_glbl,
  input  logic               rst_glbl,
  input  logic               xgmii_tx_rdy,
  input  logic               xgmii_rx_rdy,
  input  logic               rx_sync,
  input  logic               force_linkdown,
  output logic               pcs_rst,
  output logic               link_up,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned MAX_A = (RST_PULSE > TX_TIMEOUT) ? RST_PULSE : TX_TIMEOUT;
  localparam int unsigned MAX_B = (LOCK_TIMEOUT > HOLDOFF) ? LOCK_TIMEOUT : HOLDOFF;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_P = (MAX_C > DEBOUNCE) ? MAX_C : DEBOUNCE;
  localparam int unsigned TMR_W = $clog2(MAX_P) + 1;

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_PULSE - 1);
  localparam logic [TMR_W-1:0] TX_LAST   = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF - 1);
`ifdef G10_LINK_DEBOUNCE_EN
  localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE - 1);
`endif

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_TX   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_UP        = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_d;
  logic [2:0]         meta_q, sync_q;
  logic               tx_s, rx_s, lk_s;
  logic               loss;

  // Two-flop synchronisers for the wrapper status lines: {tx, rx, lock}
  always_ff @(posedge clk_glbl or negedge rst_glbl) begin
    if (!rst_glbl) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {xgmii_tx_rdy, xgmii_rx_rdy, rx_sync};
      sync_q <= meta_q;
    end
  end

  assign tx_s = sync_q[2];
  assign rx_s = sync_q[1];
  assign lk_s = sync_q[0];

  // Next-state, timer and retry logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    retry_d = retry_cnt;
    loss    = !(tx_s && rx_s && lk_s);

    case (state_q)
      ST_RESET: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_s)                    state_d = ST_WAIT_LOCK;
        else if (timer_q == TX_LAST) state_d = ST_HOLDOFF;
      end
      ST_WAIT_LOCK: begin
        if (!loss)                               state_d = ST_UP;
        else if (!tx_s || timer_q == LOCK_LAST)  state_d = ST_HOLDOFF;
      end
      ST_UP: begin
`ifdef G10_LINK_DEBOUNCE_EN
        // Timer doubles as the consecutive-loss counter while up
        if (!loss)                    timer_d = '0;
        else if (timer_q == DEB_LAST) state_d = ST_HOLDOFF;
`else
        timer_d = '0;
        if (loss) state_d = ST_HOLDOFF;
`endif
      end
      ST_HOLDOFF: begin
        if (timer_q == HOLD_LAST) state_d = ST_RESET;
      end
      default: state_d = ST_RESET;
    endcase

    // Forced link-down wins over everything and pins the timer at zero
    if (force_linkdown) state_d = ST_HOLDOFF;
    if (force_linkdown || (state_d != state_q)) timer_d = '0;

    if ((state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF) && !(&retry_cnt))
      retry_d = retry_cnt + RETRY_W'(1);
  end

  // State register and registered outputs
  always_ff @(posedge clk_glbl or negedge rst_glbl) begin
    if (!rst_glbl) begin
      state_q   <= ST_RESET;
      timer_q   <= '0;
      retry_cnt <= '0;
      pcs_rst   <= 1'b1;
      link_up   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_cnt <= retry_d;
      pcs_rst   <= (state_d == ST_RESET) || (state_d == ST_HOLDOFF);
      link_up   <= (state_q == ST_UP);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_g10_link_ctrl.sv
// tb_g10_link_ctrl: self-checking bench for g10_link_ctrl against a behavioural reference model.
// Honours G10_LINK_DEBOUNCE_EN the same way as the design.
module tb_g10_link_ctrl;

  localparam int unsigned RST_PULSE    = 4;
  localparam int unsigned TX_TIMEOUT   = 16;
  localparam int unsigned LOCK_TIMEOUT = 32;
  localparam int unsigned HOLDOFF      = 8;
  localparam int unsigned DEBOUNCE     = 5;
  localparam int unsigned RETRY_W      = 2;
  localparam int          RMAX         = (1 << RETRY_W) - 1;
`ifdef G10_LINK_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic               clk_glbl = 1'b0;
  logic               rst_glbl = 1'b0;
  logic               xgmii_tx_rdy = 1'b0;
  logic               xgmii_rx_rdy = 1'b0;
  logic               rx_sync = 1'b0;
  logic               force_linkdown = 1'b0;
  logic               pcs_rst;
  logic               link_up;
  logic [2:0]         state;
  logic [RETRY_W-1:0] retry_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase number, cycles spent in phase, consecutive loss run
  int         m_st, m_t, m_run, m_retry;
  bit         m_link, m_pcs;
  logic [2:0] m_s1, m_s2;

  g10_link_ctrl #(
    .RST_PULSE(RST_PULSE), .TX_TIMEOUT(TX_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .HOLDOFF(HOLDOFF), .DEBOUNCE(DEBOUNCE), .RETRY_W(RETRY_W)
  ) dut (
    .clk_glbl(clk_glbl), .rst_glbl(rst_glbl),
    .xgmii_tx_rdy(xgmii_tx_rdy), .xgmii_rx_rdy(xgmii_rx_rdy), .rx_sync(rx_sync),
    .force_linkdown(force_linkdown),
    .pcs_rst(pcs_rst), .link_up(link_up), .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk_glbl = ~clk_glbl;

  function automatic void model_reset();
    m_st = 0; m_t = 0; m_run = 0; m_retry = 0;
    m_link = 1'b0; m_pcs = 1'b1;
    m_s1 = 3'b000; m_s2 = 3'b000;
  endfunction

  function automatic void model_edge(input logic [2:0] din, input logic fd);
    int nst;
    bit good;
    good = (m_s2 == 3'b111);
    nst  = m_st;
    case (m_st)
      0: if (m_t == RST_PULSE - 1) nst = 1;
      1: if (m_s2[2]) nst = 2; else if (m_t == TX_TIMEOUT - 1) nst = 4;
      2: if (good) nst = 3; else if (!m_s2[2] || m_t == LOCK_TIMEOUT - 1) nst = 4;
      3: begin
        m_run = good ? 0 : m_run + 1;
        if (DEB_EN ? (m_run >= DEBOUNCE) : !good) nst = 4;
      end
      4: if (m_t == HOLDOFF - 1) nst = 0;
      default: nst = 0;
    endcase
    if (fd) nst = 4;
    if (nst == 4 && m_st != 4 && m_retry < RMAX) m_retry++;
    m_link = (m_st == 3);
    m_pcs  = (nst == 0 || nst == 4);
    m_t    = (fd || nst != m_st) ? 0 : m_t + 1;
    if (nst != m_st) m_run = 0;
    m_st = nst;
    m_s2 = m_s1;
    m_s1 = din;
  endfunction

  task automatic drive(input logic [2:0] din, input logic fd);
    {xgmii_tx_rdy, xgmii_rx_rdy, rx_sync} = din;
    force_linkdown = fd;
    @(posedge clk_glbl);
    model_edge(din, fd);
    @(negedge clk_glbl);
  endtask

  task automatic do_reset();
    @(negedge clk_glbl);
    rst_glbl = 1'b0;
    {xgmii_tx_rdy, xgmii_rx_rdy, rx_sync, force_linkdown} = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk_glbl);
    rst_glbl = 1'b1;
  endtask

  task automatic bring_up(input int n);
    for (int c = 0; c < n; c++) drive(3'b111, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk_glbl);
    rst_glbl = 1'b0;
    repeat (2) @(negedge clk_glbl);
    vectors++; if (pcs_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pcs_rst got=%b want=1", pcs_rst); end
    vectors++; if (link_up !== 1'b0) begin miscompares++; $display("FAIL reset_link_up got=%b want=0", link_up); end
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d want=0", state); end
    vectors++; if (retry_cnt !== '0) begin miscompares++; $display("FAIL reset_retry got=%0d want=0", retry_cnt); end
  endtask

  task automatic test_bringup();
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      drive({c >= 10, c >= 20, c >= 20}, 1'b0);
      vectors++;
      if ({pcs_rst, link_up, state, retry_cnt} !== {m_pcs, m_link, 3'(m_st), 2'(m_retry)}) begin
        miscompares++;
        $display("FAIL bringup c=%0d got pcs=%b up=%b st=%0d rc=%0d want pcs=%b up=%b st=%0d rc=%0d",
                 c, pcs_rst, link_up, state, retry_cnt, m_pcs, m_link, m_st, m_retry);
      end
      if (c == 3 || c == 4) begin
        vectors++;
        if (pcs_rst !== (c == 3)) begin miscompares++; $display("FAIL bringup_pcs_rst c=%0d got=%b want=%b", c, pcs_rst, c == 3); end
      end
      if (c == 24) begin
        vectors++;
        if ({link_up, retry_cnt} !== {1'b1, 2'd0}) begin
          miscompares++; $display("FAIL bringup_up c=24 got up=%b rc=%0d want up=1 rc=0", link_up, retry_cnt);
        end
      end
    end
  endtask

  task automatic test_tx_timeout();
    int k, exp_rc;
    do_reset();
    for (int c = 1; c <= 112; c++) begin
      drive(3'b000, 1'b0);
      vectors++;
      if ({pcs_rst, link_up, state, retry_cnt} !== {m_pcs, m_link, 3'(m_st), 2'(m_retry)}) begin
        miscompares++;
        $display("FAIL tx_timeout c=%0d got pcs=%b up=%b st=%0d rc=%0d want pcs=%b up=%b st=%0d rc=%0d",
                 c, pcs_rst, link_up, state, retry_cnt, m_pcs, m_link, m_st, m_retry);
      end
      // Holdoff is entered after 4 reset + 16 wait cycles, then every 28 cycles
      if (c >= 21 && (c - 21) % 28 == 0) begin
        k = (c - 21) / 28;
        exp_rc = (k + 1 > RMAX) ? RMAX : k + 1;
        vectors++;
        if ({state, retry_cnt, pcs_rst} !== {3'd4, 2'(exp_rc), 1'b1}) begin
          miscompares++;
          $display("FAIL tx_timeout_retry attempt=%0d got st=%0d rc=%0d pcs=%b want st=4 rc=%0d pcs=1",
                   k + 1, state, retry_cnt, pcs_rst, exp_rc);
        end
      end
    end
  endtask

  task automatic test_link_loss();
    int lens[$];
    int base, exp_rc, hit_c;
    bit expect_drop;
    do_reset();
    bring_up(10);
    vectors++; if (link_up !== 1'b1) begin miscompares++; $display("FAIL loss_pre got up=%b want 1", link_up); end
    lens.push_back(1);
`ifdef G10_LINK_DEBOUNCE_EN
    lens.push_back(4);
    lens.push_back(5);
`endif
    foreach (lens[i]) begin
      base        = m_retry;
      expect_drop = DEB_EN ? (lens[i] >= int'(DEBOUNCE)) : 1'b1;
      hit_c       = (DEB_EN ? int'(DEBOUNCE) : 1) + 2;
      exp_rc      = expect_drop ? ((base + 1 > RMAX) ? RMAX : base + 1) : base;
      for (int c = 0; c < lens[i] + 11; c++) begin
        drive((c < lens[i]) ? 3'b110 : 3'b111, 1'b0);
        vectors++;
        if ({pcs_rst, link_up, state, retry_cnt} !== {m_pcs, m_link, 3'(m_st), 2'(m_retry)}) begin
          miscompares++;
          $display("FAIL link_loss len=%0d c=%0d got pcs=%b up=%b st=%0d rc=%0d want pcs=%b up=%b st=%0d rc=%0d",
                   lens[i], c, pcs_rst, link_up, state, retry_cnt, m_pcs, m_link, m_st, m_retry);
        end
        if (c == hit_c) begin
          vectors++;
          if ({link_up, retry_cnt} !== {!expect_drop, 2'(exp_rc)}) begin
            miscompares++;
            $display("FAIL link_loss_result len=%0d got up=%b rc=%0d want up=%b rc=%0d",
                     lens[i], link_up, retry_cnt, !expect_drop, exp_rc);
          end
        end
      end
    end
  endtask

  task automatic test_force_linkdown();
    int exp_rc;
    do_reset();
    bring_up(10);
    exp_rc = (m_retry + 1 > RMAX) ? RMAX : m_retry + 1;
    for (int c = 0; c < 62; c++) begin
      drive(3'b111, c < 50);
      vectors++;
      if ({pcs_rst, link_up, state, retry_cnt} !== {m_pcs, m_link, 3'(m_st), 2'(m_retry)}) begin
        miscompares++;
        $display("FAIL force c=%0d got pcs=%b up=%b st=%0d rc=%0d want pcs=%b up=%b st=%0d rc=%0d",
                 c, pcs_rst, link_up, state, retry_cnt, m_pcs, m_link, m_st, m_retry);
      end
      // Held in holdoff during the 50 forced cycles, then 8 holdoff cycles, then reset
      if (c <= 57) begin
        vectors++;
        if ({state, retry_cnt} !== {((c <= 56) ? 3'd4 : 3'd0), 2'(exp_rc)} || (c >= 1 && link_up !== 1'b0)) begin
          miscompares++;
          $display("FAIL force_hold c=%0d got st=%0d rc=%0d up=%b want st=%0d rc=%0d up=0",
                   c, state, retry_cnt, link_up, (c <= 56) ? 4 : 0, exp_rc);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      drive(3'b111, c >= 6 && c <= 9);
      vectors++;
      if ({pcs_rst, link_up, state, retry_cnt} !== {m_pcs, m_link, 3'(m_st), 2'(m_retry)}) begin
        miscompares++;
        $display("FAIL simul c=%0d got pcs=%b up=%b st=%0d rc=%0d want pcs=%b up=%b st=%0d rc=%0d",
                 c, pcs_rst, link_up, state, retry_cnt, m_pcs, m_link, m_st, m_retry);
      end
      vectors++;
      if (link_up !== 1'b0 || (c >= 6 && state !== 3'd4)) begin
        miscompares++;
        $display("FAIL simul_override c=%0d got up=%b st=%0d want up=0 st=%0d", c, link_up, state, (c >= 6) ? 4 : int'(state));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bring_up(10);
    drive(3'b111, 1'b1);
    bring_up(25);
    vectors++;
    if ({link_up, retry_cnt} !== {1'b1, 2'd1}) begin
      miscompares++; $display("FAIL async_pre got up=%b rc=%0d want up=1 rc=1", link_up, retry_cnt);
    end
    #2 rst_glbl = 1'b0;
    #1;
    vectors++;
    if ({pcs_rst, link_up, state, retry_cnt} !== {1'b1, 1'b0, 3'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL async_reset got pcs=%b up=%b st=%0d rc=%0d want pcs=1 up=0 st=0 rc=0",
               pcs_rst, link_up, state, retry_cnt);
    end
    model_reset();
    @(negedge clk_glbl);
    rst_glbl = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] din;
    logic       fd;
    for (int b = 0; b < 5; b++) begin
      do_reset();
      din = 3'b111;
      for (int c = 0; c < 300; c++) begin
        for (int k = 0; k < 3; k++) begin
          if (din[k] ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0)) din[k] = ~din[k];
        end
        fd = ($urandom_range(0, 99) < 2);
        drive(din, fd);
        vectors++;
        if ({pcs_rst, link_up, state, retry_cnt} !== {m_pcs, m_link, 3'(m_st), 2'(m_retry)}) begin
          miscompares++;
          $display("FAIL random b=%0d c=%0d got pcs=%b up=%b st=%0d rc=%0d want pcs=%b up=%b st=%0d rc=%0d",
                   b, c, pcs_rst, link_up, state, retry_cnt, m_pcs, m_link, m_st, m_retry);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bringup();
    test_tx_timeout();
    test_link_loss();
    test_force_linkdown();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
